// File: rtl/fdivsqrt_ctrl_if.sv
// Request/response bundle between the execute stage, the div/sqrt datapath and its sequencer.
// The counter width is derived here so the interface and the controller agree on CountE.
interface fdivsqrt_ctrl_if #(
   parameter int DIVb      = 26,
   parameter int RADIX     = 4,
   parameter int DIVCOPIES = 2
);
   localparam int LOGR = (RADIX == 4) ? 2 : 1;
   localparam int B    = LOGR * DIVCOPIES;
   localparam int N    = (DIVb + 1 + B - 1) / B;
   localparam int CW   = $clog2(N + 1);

   logic          FDivStartE;
   logic          SqrtOpE;
   logic          SpecialCaseE;
   logic          FlushE;
   logic          StallM;
   logic          IFDivStartE;
   logic          FDivBusyE;
   logic          SqrtE;
   logic          FDivDoneE;
   logic [CW-1:0] CountE;

   modport master (
      output FDivStartE, SqrtOpE, SpecialCaseE, FlushE, StallM,
      input  IFDivStartE, FDivBusyE, SqrtE, FDivDoneE, CountE
   );

   modport slave (
      input  FDivStartE, SqrtOpE, SpecialCaseE, FlushE, StallM,
      output IFDivStartE, FDivBusyE, SqrtE, FDivDoneE, CountE
   );
endinterface

// File: rtl/fdivsqrt_ctrl.sv
// Sequencer for the iterative divide/sqrt datapath: start select, register enable,
// recurrence cycle count, latched sqrt mode and completion with stall/flush handling.
module fdivsqrt_ctrl #(
   parameter int DIVb      = 26,
   parameter int RADIX     = 4,
   parameter int DIVCOPIES = 2
) (
   input  logic           clk,
   input  logic           reset,
   fdivsqrt_ctrl_if.slave bus
);
   localparam int LOGR = (RADIX == 4) ? 2 : 1;
   localparam int B    = LOGR * DIVCOPIES;
   localparam int N    = (DIVb + 1 + B - 1) / B;
   localparam int CW   = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic          r_sqrt;
   logic          w_sqrt_next;
   logic          w_accept;
   logic          w_ifdiv_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_sqrt  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_sqrt  <= w_sqrt_next;
      end
   end

   // Accept is already gated by FlushE, so a flush can never raise the init select.
   always_comb begin
      w_state_next  = r_state;
      w_count_next  = r_count;
      w_sqrt_next   = r_sqrt;
      w_ifdiv_start = 1'b0;
      w_accept      = (r_state == IDLE) & bus.FDivStartE & ~bus.FlushE;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_sqrt_next = bus.SqrtOpE;
               if (bus.SpecialCaseE) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next  = BUSY;
                  w_count_next  = CW'(N);
                  w_ifdiv_start = 1'b1;
               end
            end
         end
         BUSY: begin
            if (r_count <= CW'(1)) begin
               w_state_next = DONE;
               w_count_next = '0;
            end else begin
               w_count_next = r_count - 1'b1;
            end
         end
         DONE: begin
            if (!bus.StallM) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_count_next = '0;
         end
      endcase

      if (bus.FlushE) begin
         w_state_next = IDLE;
         w_count_next = '0;
      end
   end

   // Busy drops in DONE so the datapath holds its result while M is stalled.
   assign bus.IFDivStartE = w_ifdiv_start;
   assign bus.FDivBusyE   = w_ifdiv_start | (r_state == BUSY);
   assign bus.FDivDoneE   = (r_state == DONE);
   assign bus.SqrtE       = r_sqrt;
   assign bus.CountE      = r_count;
endmodule

// File: tb/tb_fdivsqrt_ctrl.sv
// Cycle-level scoreboard bench: drivers queue the expected outputs for each cycle,
// monitors pop and compare on the falling edge. Two instances cover N=7 and N=14.
module tb_fdivsqrt_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1 = 1'b1;
   logic rst2 = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic es1 = 1'b0;
   logic es2 = 1'b0;

   typedef struct packed {
      logic       ifs;
      logic       busy;
      logic       sqrt;
      logic       done;
      logic [7:0] cnt;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   exp_t m1;
   exp_t m2;

   fdivsqrt_ctrl_if #(.DIVb(26), .RADIX(4), .DIVCOPIES(2)) bus1();
   fdivsqrt_ctrl_if #(.DIVb(52), .RADIX(2), .DIVCOPIES(4)) bus2();

   fdivsqrt_ctrl #(.DIVb(26), .RADIX(4), .DIVCOPIES(2)) dut1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus1)
   );

   fdivsqrt_ctrl #(.DIVb(52), .RADIX(2), .DIVCOPIES(4)) dut2 (
      .clk   (clk),
      .reset (rst2),
      .bus   (bus2)
   );

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (q1.size() > 0) begin
         m1 = q1.pop_front();
         chk("d1_ifdivstart", int'(bus1.IFDivStartE), int'(m1.ifs));
         chk("d1_busy",       int'(bus1.FDivBusyE),   int'(m1.busy));
         chk("d1_sqrt",       int'(bus1.SqrtE),       int'(m1.sqrt));
         chk("d1_done",       int'(bus1.FDivDoneE),   int'(m1.done));
         chk("d1_count",      int'(bus1.CountE),      int'(m1.cnt));
      end
   end

   always @(negedge clk) begin
      if (q2.size() > 0) begin
         m2 = q2.pop_front();
         chk("d2_ifdivstart", int'(bus2.IFDivStartE), int'(m2.ifs));
         chk("d2_busy",       int'(bus2.FDivBusyE),   int'(m2.busy));
         chk("d2_sqrt",       int'(bus2.SqrtE),       int'(m2.sqrt));
         chk("d2_done",       int'(bus2.FDivDoneE),   int'(m2.done));
         chk("d2_count",      int'(bus2.CountE),      int'(m2.cnt));
      end
   end

   task automatic drv1(input logic s, so, sc, fl, st, rs,
                       input logic e_ifs, e_busy, e_done, input int e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst1 = rs;
      bus1.FDivStartE = s;   bus1.SqrtOpE = so;  bus1.SpecialCaseE = sc;
      bus1.FlushE     = fl;  bus1.StallM  = st;
      e.ifs = e_ifs; e.busy = e_busy; e.sqrt = es1; e.done = e_done; e.cnt = 8'(e_cnt);
      q1.push_back(e);
   endtask

   task automatic drv2(input logic s, so, fl, rs,
                       input logic e_ifs, e_busy, e_done, input int e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst2 = rs;
      bus2.FDivStartE = s;   bus2.SqrtOpE = so;  bus2.SpecialCaseE = 1'b0;
      bus2.FlushE     = fl;  bus2.StallM  = 1'b0;
      e.ifs = e_ifs; e.busy = e_busy; e.sqrt = es2; e.done = e_done; e.cnt = 8'(e_cnt);
      q2.push_back(e);
   endtask

   task automatic idle1();
      drv1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Normal operation on the N=7 instance; noise drives FDivStartE outside IDLE.
   task automatic op1(input logic so, input logic toggle, input logic noise, input int stall_n);
      $display("op1 normal sqrt=%0d toggle=%0d noise=%0d stall=%0d at cyc=%0d",
               so, toggle, noise, stall_n, cyc + 1);
      drv1(1, so, 0, 0, 0, 0, 1, 1, 0, 0);
      es1 = so;
      for (int k = 1; k <= 7; k++) begin
         drv1(noise, toggle ? (so ^ k[0]) : 1'b0, 0, 0, 0, 0, 0, 1, 0, 8 - k);
      end
      for (int j = 0; j < stall_n; j++) begin
         drv1(noise, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      end
      drv1(noise, 0, 0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      bus1.FDivStartE = 0; bus1.SqrtOpE = 0; bus1.SpecialCaseE = 0; bus1.FlushE = 0; bus1.StallM = 0;
      bus2.FDivStartE = 0; bus2.SqrtOpE = 0; bus2.SpecialCaseE = 0; bus2.FlushE = 0; bus2.StallM = 0;

      $display("reset both instances");
      drv1(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      drv1(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle1();
      idle1();

      op1(0, 0, 0, 0);
      idle1();
      op1(1, 1, 1, 0);
      idle1();

      $display("op1 special case sqrt=0 at cyc=%0d", cyc + 1);
      drv1(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      es1 = 0;
      drv1(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle1();

      op1(1, 0, 0, 3);
      idle1();

      $display("op1 start with flush in IDLE at cyc=%0d", cyc + 1);
      drv1(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      idle1();

      $display("op1 flush mid-busy at cyc=%0d", cyc + 1);
      drv1(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      es1 = 0;
      drv1(0, 0, 0, 0, 0, 0, 0, 1, 0, 7);
      drv1(0, 0, 0, 0, 0, 0, 0, 1, 0, 6);
      drv1(0, 0, 0, 1, 0, 0, 0, 1, 0, 5);
      drv1(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      op1(1, 0, 0, 0);
      idle1();

      $display("op1 back-to-back pair");
      op1(0, 0, 0, 0);
      op1(1, 0, 0, 0);
      idle1();

      $display("op1 flush while stalled in DONE at cyc=%0d", cyc + 1);
      drv1(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      es1 = 0;
      for (int k = 1; k <= 7; k++) drv1(0, 0, 0, 0, 0, 0, 0, 1, 0, 8 - k);
      drv1(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      drv1(0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
      drv1(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      idle1();

      $display("op2 N=14 normal sqrt=1 at cyc=%0d", cyc + 1);
      drv2(0, 0, 0, 0, 0, 0, 0, 0);
      drv2(1, 1, 0, 0, 1, 1, 0, 0);
      es2 = 1;
      for (int k = 1; k <= 14; k++) drv2(0, 0, 0, 0, 0, 1, 0, 15 - k);
      drv2(0, 0, 0, 0, 0, 0, 1, 0);
      drv2(0, 0, 0, 0, 0, 0, 0, 0);

      $display("op2 async reset mid-busy at cyc=%0d", cyc + 1);
      drv2(1, 1, 0, 0, 1, 1, 0, 0);
      for (int k = 1; k <= 5; k++) drv2(0, 0, 0, 0, 0, 1, 0, 15 - k);
      es2 = 0;
      drv2(0, 0, 0, 1, 0, 0, 0, 0);
      drv2(0, 0, 0, 1, 0, 0, 0, 0);
      drv2(0, 0, 0, 0, 0, 0, 0, 0);

      $display("op2 N=14 recovery sqrt=0 at cyc=%0d", cyc + 1);
      drv2(1, 0, 0, 0, 1, 1, 0, 0);
      for (int k = 1; k <= 14; k++) drv2(0, 0, 0, 0, 0, 1, 0, 15 - k);
      drv2(0, 0, 0, 0, 0, 0, 1, 0);
      drv2(0, 0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1);
   end
endmodule
